// File: rtl/bldc_hall_enc_emulator.sv
// bldc_hall_enc_emulator
//   Emulates the sensors of a BLDC motor: a 6-step hall pattern and a
//   quadrature encoder advanced at a commanded rate and direction. It also
//   tracks the signed encoder position a downstream counter should read.
//   Fault modes override only the hall lines so that hall fault/disconnect
//   detection can be exercised.
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   en          1 = running
//   dir         0 = forward, 1 = reverse
//   period      clk cycles per encoder state, 0 = halted
//   fault_mode  00 none, 01 hall=000, 10 hall=111, 11 hall frozen
//   hall        emulated hall lines (registered)
//   enc         emulated quadrature {A,B} (registered)
//   hall_strobe 1-cycle pulse on a hall index step
//   pos_count   signed encoder-state position, wraps mod 2^POS_WIDTH
module bldc_hall_enc_emulator #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned ENC_PER_HALL = 4,
  parameter int unsigned POS_WIDTH    = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    dir,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [1:0]              fault_mode,
  output logic [2:0]              hall,
  output logic [1:0]              enc,
  output logic                    hall_strobe,
  output logic [POS_WIDTH-1:0]    pos_count
);

  localparam int unsigned SUB_W = (ENC_PER_HALL > 1) ? $clog2(ENC_PER_HALL) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(ENC_PER_HALL - 1);

  typedef enum logic [1:0] {
    FLT_NONE   = 2'b00,
    FLT_LOW    = 2'b01,
    FLT_HIGH   = 2'b10,
    FLT_FREEZE = 2'b11
  } flt_e;

  logic [PERIOD_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [SUB_W-1:0]        sub_q, sub_d;
  logic [2:0]              hall_idx_q, hall_idx_d;
  logic [1:0]              enc_idx_q, enc_idx_d;
  logic [2:0]              hall_q, hall_d;
  logic [1:0]              enc_q, enc_d;
  logic                    strobe_q, strobe_d;
  logic [POS_WIDTH-1:0]    pos_q, pos_d;
  logic                    run, tick;
  flt_e                    flt;

  function automatic logic [2:0] hall_code(input logic [2:0] idx);
    case (idx)
      3'd0:    hall_code = 3'b001;
      3'd1:    hall_code = 3'b011;
      3'd2:    hall_code = 3'b010;
      3'd3:    hall_code = 3'b110;
      3'd4:    hall_code = 3'b100;
      default: hall_code = 3'b101;
    endcase
  endfunction

  function automatic logic [1:0] gray_code(input logic [1:0] idx);
    case (idx)
      2'd0:    gray_code = 2'b00;
      2'd1:    gray_code = 2'b01;
      2'd2:    gray_code = 2'b11;
      default: gray_code = 2'b10;
    endcase
  endfunction

  always_comb begin
    run  = en && (period != '0);
    // >= rather than == so that shrinking period below tick_cnt ticks at once
    tick = run && (tick_cnt_q >= period - PERIOD_WIDTH'(1));
    flt  = flt_e'(fault_mode);

    tick_cnt_d = tick_cnt_q;
    sub_d      = sub_q;
    hall_idx_d = hall_idx_q;
    enc_idx_d  = enc_idx_q;
    pos_d      = pos_q;
    strobe_d   = 1'b0;

    if (!run || tick) tick_cnt_d = '0;
    else              tick_cnt_d = tick_cnt_q + PERIOD_WIDTH'(1);

    if (tick) begin
      if (!dir) begin
        enc_idx_d = enc_idx_q + 2'd1;
        pos_d     = pos_q + POS_WIDTH'(1);
        if (sub_q == SUB_MAX) begin
          sub_d      = '0;
          hall_idx_d = (hall_idx_q == 3'd5) ? 3'd0 : hall_idx_q + 3'd1;
          strobe_d   = 1'b1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end else begin
        enc_idx_d = enc_idx_q - 2'd1;
        pos_d     = pos_q - POS_WIDTH'(1);
        if (sub_q == '0) begin
          sub_d      = SUB_MAX;
          hall_idx_d = (hall_idx_q == 3'd0) ? 3'd5 : hall_idx_q - 3'd1;
          strobe_d   = 1'b1;
        end else begin
          sub_d = sub_q - SUB_W'(1);
        end
      end
    end

    enc_d = gray_code(enc_idx_d);

    // Freeze holds whatever hall shows when the mode is entered, then keeps it
    case (flt)
      FLT_LOW:    hall_d = 3'b000;
      FLT_HIGH:   hall_d = 3'b111;
      FLT_FREEZE: hall_d = hall_q;
      default:    hall_d = hall_code(hall_idx_d);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      sub_q      <= '0;
      hall_idx_q <= '0;
      enc_idx_q  <= '0;
      hall_q     <= 3'b001;
      enc_q      <= 2'b00;
      strobe_q   <= 1'b0;
      pos_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sub_q      <= sub_d;
      hall_idx_q <= hall_idx_d;
      enc_idx_q  <= enc_idx_d;
      hall_q     <= hall_d;
      enc_q      <= enc_d;
      strobe_q   <= strobe_d;
      pos_q      <= pos_d;
    end
  end

  assign hall        = hall_q;
  assign enc         = enc_q;
  assign hall_strobe = strobe_q;
  assign pos_count   = pos_q;

endmodule

// File: tb/tb_bldc_hall_enc_emulator.sv
// Testbench for bldc_hall_enc_emulator. The reference model tracks an
// unbounded signed step position; hall, encoder and position outputs are
// derived from it arithmetically (position mod 24 / mod 4 / mod 2^15).
module tb_bldc_hall_enc_emulator;

  localparam int unsigned PW  = 16;
  localparam int unsigned EPH = 4;
  localparam int unsigned POSW = 15;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            dir = 1'b0;
  logic [PW-1:0]   period = '0;
  logic [1:0]      fault_mode = 2'b00;
  logic [2:0]      hall;
  logic [1:0]      enc;
  logic            hall_strobe;
  logic [POSW-1:0] pos_count;

  int checks = 0;
  int failures = 0;

  // model state
  longint          m_pos = 0;
  int              m_tc = 0;
  logic [2:0]      m_hall = 3'b001;
  logic            m_strobe = 1'b0;

  logic [2:0] HALL_TAB [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [1:0] GRAY_TAB [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  bldc_hall_enc_emulator #(
    .PERIOD_WIDTH(PW),
    .ENC_PER_HALL(EPH),
    .POS_WIDTH(POSW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .dir(dir),
    .period(period),
    .fault_mode(fault_mode),
    .hall(hall),
    .enc(enc),
    .hall_strobe(hall_strobe),
    .pos_count(pos_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int modp(input longint p, input int m);
    return int'(((p % m) + m) % m);
  endfunction

  function automatic logic [2:0] hall_of(input longint p);
    return HALL_TAB[modp(p, 6 * EPH) / EPH];
  endfunction

  function automatic logic [1:0] enc_of(input longint p);
    return GRAY_TAB[modp(p, 4)];
  endfunction

  // Model update at the active edge, from inputs held since the last negedge
  task automatic model_edge();
    logic   run, tk;
    longint old;
    run = en && (period != 0);
    tk  = run && (m_tc >= int'(period) - 1);
    if (!reset_n) begin
      m_pos = 0; m_tc = 0; m_hall = 3'b001; m_strobe = 1'b0;
      return;
    end
    if (!run || tk) m_tc = 0;
    else            m_tc = m_tc + 1;
    m_strobe = 1'b0;
    if (tk) begin
      old = m_pos;
      m_pos = dir ? m_pos - 1 : m_pos + 1;
      // hall steps whenever the position crosses a multiple of EPH
      m_strobe = dir ? (modp(old, EPH) == 0) : (modp(m_pos, EPH) == 0);
    end
    case (fault_mode)
      2'b00: m_hall = hall_of(m_pos);
      2'b01: m_hall = 3'b000;
      2'b10: m_hall = 3'b111;
      default: ;
    endcase
  endtask

  task automatic cyc(input int n = 1);
    logic [POSW-1:0] ep;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      ep = m_pos[POSW-1:0];
      check("hall", 32'(hall), 32'(m_hall));
      check("enc", 32'(enc), 32'(enc_of(m_pos)));
      check("strobe", 32'(hall_strobe), 32'(m_strobe));
      check("pos", 32'(pos_count), 32'(ep));
    end
  endtask

  task automatic do_reset(input int n = 2);
    reset_n = 1'b0;
    cyc(n);
    reset_n = 1'b1;
  endtask

  initial begin
    // startup reset
    do_reset(2);
    check("rst_hall", 32'(hall), 32'h1);
    check("rst_enc", 32'(enc), 32'h0);
    check("rst_pos", 32'(pos_count), 32'h0);

    // forward, period 3: 72 clocks is 24 ticks, one electrical revolution
    en = 1'b1; dir = 1'b0; period = 16'd3;
    cyc(72);
    check("rev_pos24", 32'(pos_count), 32'd24);
    check("rev_hall", 32'(hall), 32'h1);

    // reset mid-run wins over en
    do_reset(2);
    check("midrst_pos", 32'(pos_count), 32'h0);
    check("midrst_strobe", 32'(hall_strobe), 32'h0);

    // reverse from reset at period 1
    dir = 1'b1; period = 16'd1;
    cyc(1);
    check("rev1_enc", 32'(enc), 32'h2);
    check("rev1_hall", 32'(hall), 32'h5);
    check("rev1_strobe", 32'(hall_strobe), 32'h1);
    check("rev1_pos", 32'(pos_count), 32'h7fff);
    cyc(3);
    check("rev3_hall", 32'(hall), 32'h5);

    // 5 forward then 5 reverse retraces to origin
    en = 1'b0; do_reset(2); en = 1'b1;
    dir = 1'b0; cyc(5);
    dir = 1'b1; cyc(5);
    check("retrace_pos", 32'(pos_count), 32'h0);
    check("retrace_enc", 32'(enc), 32'h0);
    check("retrace_hall", 32'(hall), 32'h1);

    // fault modes while running
    period = 16'd2; dir = 1'b0;
    cyc(7);
    fault_mode = 2'b01; cyc(9);
    fault_mode = 2'b10; cyc(6);
    fault_mode = 2'b00; cyc(3);
    fault_mode = 2'b11; cyc(12);
    fault_mode = 2'b00; cyc(4);

    // period shrink below tick_cnt ticks next cycle
    en = 1'b0; do_reset(2); en = 1'b1;
    period = 16'd100;
    cyc(50);
    check("slow_enc", 32'(enc), 32'h0);
    period = 16'd10;
    cyc(1);
    check("shrink_enc", 32'(enc), 32'h1);
    // halt via period 0 and via en, then resume
    cyc(4);
    period = 16'd0; cyc(7);
    period = 16'd5; en = 1'b0; cyc(6);
    en = 1'b1; cyc(12);

    // randomized segments
    for (int s = 0; s < 60; s++) begin
      en         = ($urandom_range(0, 7) != 0);
      dir        = 1'($urandom_range(0, 1));
      period     = 16'($urandom_range(0, 6));
      fault_mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 15) == 0) do_reset(int'($urandom_range(1, 2)));
      cyc(int'($urandom_range(5, 60)));
    end
    fault_mode = 2'b00;

    // positive wrap of pos_count
    en = 1'b0; do_reset(2);
    en = 1'b1; dir = 1'b0; period = 16'd1;
    cyc(32767);
    check("wrap_max", 32'(pos_count), 32'h7fff);
    cyc(1);
    check("wrap_zero", 32'(pos_count), 32'h0);
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
